// File: rtl/aes_decrypt_iter_if.sv
// Handshake bundle for the iterative AES decryption core.
// A transfer happens on a rising clk edge where valid && ready are both high; the
// producer holds its payload stable while valid is high and ready is low.
interface aes_decrypt_iter_if #(
  parameter int N = 128
);
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [N-1:0]   key;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;

  modport master (
    output in_valid, in_data, key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 decryption: key schedule one word per cycle, then one inverse round per cycle.
// Optional key cache (skip key expansion on repeated key) enabled by defining KEY_CACHE_EN.
module aes_decrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              reset,
  aes_decrypt_iter_if.slave bus,
  output logic [1:0]        o_dbg_state
);

  localparam int NW = 4 * (Nr + 1);
  localparam bit LEGAL = (N == 128 && Nr == 10 && Nk == 4) ||
                         (N == 192 && Nr == 12 && Nk == 6) ||
                         (N == 256 && Nr == 14 && Nk == 8);

  generate
    if (!LEGAL) begin : g_illegal
      $error("aes_decrypt_iter: unsupported (N, Nr, Nk) combination");
    end
  endgenerate

  localparam logic [3:0] NR4   = 4'(Nr);
  localparam logic [5:0] NK6   = 6'(Nk);
  localparam logic [5:0] LAST6 = 6'(NW - 1);
  localparam logic [2:0] KMAX  = 3'(Nk - 1);

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} state_t;

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_state;
  logic [31:0]  r_w [NW];
  logic [5:0]   r_i;
  logic [2:0]   r_kmod;
  logic [7:0]   r_rcon;
  logic [3:0]   r_r;

  logic         w_accept, w_hit;
  logic [31:0]  w_prev, w_back, w_temp, w_new;
  logic [127:0] w_rk, w_inv_core, w_round;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (2+4+...+128); maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k of the block sits at [127-8k]; row = k%4, column = k/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign w_accept    = bus.in_valid && (r_fsm == S_IDLE);
  assign bus.out_data = r_state;
  assign o_dbg_state = r_fsm;

`ifdef KEY_CACHE_EN
  logic         r_cache_vld;
  logic [N-1:0] r_cache_key;

  assign w_hit = r_cache_vld && (bus.key == r_cache_key);

  // The cache is only trusted once a full expansion of the stored key has completed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= '0;
    end else if (w_accept && !w_hit) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= bus.key;
    end else if (r_fsm == S_KEYEXP && r_i == LAST6) begin
      r_cache_vld <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt     = r_fsm;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_fsm_nxt = w_hit ? S_ROUND : S_KEYEXP;
      end
      S_KEYEXP: if (r_i == LAST6) w_fsm_nxt = S_ROUND;
      S_ROUND:  if (r_r == 4'd0)  w_fsm_nxt = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_prev = r_w[r_i - 6'd1];
    w_back = r_w[r_i - NK6];
    w_temp = w_prev;
    if (r_kmod == 3'd0)                w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (Nk == 8 && r_kmod == 3'd4) w_temp = sub_word(w_prev);
    w_new = w_back ^ w_temp;
  end

  always_comb begin
    w_rk       = {r_w[{r_r, 2'b00}], r_w[{r_r, 2'b01}], r_w[{r_r, 2'b10}], r_w[{r_r, 2'b11}]};
    w_inv_core = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_rk;
    if (r_r == NR4)       w_round = r_state ^ w_rk;
    else if (r_r == 4'd0) w_round = w_inv_core;
    else                  w_round = inv_mix_columns(w_inv_core);
  end

  // Key words are not reset: they are always rewritten before being read.
  always_ff @(posedge clk) begin
    if (w_accept && !w_hit) begin
      for (int k = 0; k < Nk; k++) r_w[k] <= bus.key[N - 1 - 32*k -: 32];
    end else if (r_fsm == S_KEYEXP) begin
      r_w[r_i] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
      r_i     <= '0;
      r_kmod  <= '0;
      r_rcon  <= '0;
      r_r     <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= bus.in_data;
            r_i     <= NK6;
            r_kmod  <= 3'd0;
            r_rcon  <= 8'h01;
            r_r     <= NR4;
          end
        end
        S_KEYEXP: begin
          r_i    <= r_i + 6'd1;
          r_kmod <= (r_kmod == KMAX) ? 3'd0 : r_kmod + 3'd1;
          if (r_kmod == 3'd0) r_rcon <= xtime(r_rcon);
        end
        S_ROUND: begin
          r_state <= w_round;
          if (r_r != 4'd0) r_r <= r_r - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 vectors at all key sizes, latency,
// backpressure, busy-input immunity, no back-to-back accept, and mid-round reset.
module tb_aes_decrypt_iter;

  localparam logic [255:0] KEY_A  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef KEY_CACHE_EN
  localparam int L_REP = 11;
`else
  localparam int L_REP = 51;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_decrypt_iter_if #(.N(128)) b128 ();
  aes_decrypt_iter_if #(.N(192)) b192 ();
  aes_decrypt_iter_if #(.N(256)) b256 ();
  logic [1:0] dbg128, dbg192, dbg256;

  aes_decrypt_iter #(.N(128), .Nr(10), .Nk(4)) u128 (.clk(clk), .reset(reset), .bus(b128), .o_dbg_state(dbg128));
  aes_decrypt_iter #(.N(192), .Nr(12), .Nk(6)) u192 (.clk(clk), .reset(reset), .bus(b192), .o_dbg_state(dbg192));
  aes_decrypt_iter #(.N(256), .Nr(14), .Nk(8)) u256 (.clk(clk), .reset(reset), .bus(b256), .o_dbg_state(dbg256));

  int           sel;
  logic         tb_valid, tb_oready;
  logic [127:0] tb_ct;
  logic [255:0] tb_key;

  assign b128.in_valid  = tb_valid && (sel == 0);
  assign b192.in_valid  = tb_valid && (sel == 1);
  assign b256.in_valid  = tb_valid && (sel == 2);
  assign b128.in_data   = tb_ct;
  assign b192.in_data   = tb_ct;
  assign b256.in_data   = tb_ct;
  assign b128.key       = tb_key[255:128];
  assign b192.key       = tb_key[255:64];
  assign b256.key       = tb_key;
  assign b128.out_ready = tb_oready;
  assign b192.out_ready = tb_oready;
  assign b256.out_ready = tb_oready;

  logic         s_in_ready, s_out_valid;
  logic [127:0] s_out_data;
  always_comb begin
    case (sel)
      1:       begin s_in_ready = b192.in_ready; s_out_valid = b192.out_valid; s_out_data = b192.out_data; end
      2:       begin s_in_ready = b256.in_ready; s_out_valid = b256.out_valid; s_out_data = b256.out_data; end
      default: begin s_in_ready = b128.in_ready; s_out_valid = b128.out_valid; s_out_data = b128.out_data; end
    endcase
  end

  // scoreboard
  logic [127:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks; all driving and sampling happens on the falling edge
  task automatic accept(input int which, input logic [127:0] ct, input logic [255:0] k,
                        input logic [127:0] exp_pt);
    int n = 0;
    sel      = which;
    tb_ct    = ct;
    tb_key   = k;
    tb_valid = 1'b1;
    while (!s_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 128'(s_in_ready), 128'(1));
    @(negedge clk);
    tb_valid = 1'b0;
    exp_q.push_back(exp_pt);
    check("busy_in_ready", 128'(s_in_ready), 128'(0));
  endtask

  task automatic wait_out(input int exp_lat, input string tag, input bit busy);
    int           cyc = 0;
    logic [127:0] exp_pt;
    while (!s_out_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        tb_valid = 1'($urandom_range(0, 1));
        tb_ct    = {$urandom(), $urandom(), $urandom(), $urandom()};
        tb_key   = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    tb_valid = 1'b0;
    check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
    check({tag, "_out_valid"}, 128'(s_out_valid), 128'(1));
    exp_pt = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    check({tag, "_out_data"}, s_out_data, exp_pt);
  endtask

  task automatic release_out();
    tb_oready = 1'b1;
    @(negedge clk);
    tb_oready = 1'b0;
    check("release_in_ready", 128'(s_in_ready), 128'(1));
    check("release_out_valid", 128'(s_out_valid), 128'(0));
  endtask

  initial begin
    reset = 1'b0; sel = 0; tb_valid = 1'b0; tb_oready = 1'b0; tb_ct = '0; tb_key = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(b128.in_ready), 128'(1));
    check("rst_out_valid", 128'(b128.out_valid), 128'(0));
    check("rst_out_data", b128.out_data, 128'h0);
    check("rst_in_ready_192", 128'(b192.in_ready), 128'(1));
    check("rst_out_valid_256", 128'(b256.out_valid), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    // AES-128 known answer, cold start
    accept(0, CT_128, KEY_A, PT_A);
    wait_out(51, "aes128", 1'b0);
    release_out();

    // same key again, then hold out_ready low for 20 cycles
    accept(0, CT_128, KEY_A, PT_A);
    wait_out(L_REP, "aes128_rep", 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(s_out_valid), 128'(1));
      check("bp_out_data", s_out_data, PT_A);
      check("bp_in_ready", 128'(s_in_ready), 128'(0));
    end
    release_out();

    // new key, inputs thrashed while busy
    accept(0, CT_B, KEY_B, PT_B);
    wait_out(51, "busy_inputs", 1'b1);

    // out_ready and in_valid together in DONE: no accept on that edge
    tb_ct = CT_B; tb_key = KEY_B; tb_valid = 1'b1; tb_oready = 1'b1;
    @(negedge clk);
    tb_oready = 1'b0;
    check("no_b2b_in_ready", 128'(s_in_ready), 128'(1));
    check("no_b2b_out_valid", 128'(s_out_valid), 128'(0));
    accept(0, CT_B, KEY_B, PT_B);
    wait_out(L_REP, "after_b2b", 1'b0);
    release_out();

    // reset for one cycle while the core is at round 5
    accept(0, CT_128, KEY_A, PT_A);
    repeat (45) @(negedge clk);
    check("mid_round_out_valid", 128'(s_out_valid), 128'(0));
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(s_in_ready), 128'(1));
    check("mid_rst_out_valid", 128'(s_out_valid), 128'(0));
    check("mid_rst_out_data", s_out_data, 128'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    accept(0, CT_128, KEY_A, PT_A);
    wait_out(51, "post_reset", 1'b0);
    release_out();

    // AES-192 and AES-256 known answers
    accept(1, CT_192, KEY_A, PT_A);
    wait_out(59, "aes192", 1'b0);
    release_out();
    accept(2, CT_256, KEY_A, PT_A);
    wait_out(67, "aes256", 1'b0);
    release_out();

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative, one-round-per-clock AES decryption core for 128/192/256-bit keys. It is the sequential, area-lean counterpart to the fully combinational encrypt pipeline. It accepts a ciphertext block and key over a valid/ready handshake, expands the key schedule into an internal word store, then runs the inverse cipher from the last round key down to round 0. It sits downstream of the encrypt path in the self-test top and in any streaming datapath that needs decryption without unrolled logic.

## Interface
- N, 128, key width in bits (128, 192 or 256)
- Nr, 10, number of rounds (10, 12, 14)
- Nk, 4, key length in 32-bit words (4, 6, 8)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  ciphertext/key presented
- in_ready  output  1  core idle and able to accept
- in_data  input  128  ciphertext block
- key  input  N  cipher key
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts plaintext
- out_data  output  128  decrypted plaintext

## Operation
- States:
  - IDLE: in_ready=1.
  - KEYEXP: one schedule word per cycle.
  - ROUND: one inverse round per cycle.
  - DONE: out_valid=1.
- IDLE→KEYEXP on in_valid&&in_ready:
  - Latch in_data into the state register.
  - Write key words w[0..Nk-1] into the word store (4*(Nr+1) ≤ 60 words × 32 bits).
  - Set word index i=Nk.
- KEYEXP:
  - Each cycle compute w[i] = w[i-Nk] ^ temp, where temp follows the standard FIPS-197 rules:
    - i mod Nk == 0: RotWord, SubWord, Rcon.
    - Nk==8 and i mod 8 == 4: SubWord only.
  - Rcon is held in a register and doubled in GF(2^8) after each use.
  - When i == 4*(Nr+1)-1 is written, go to ROUND with round counter r=Nr.
- ROUND:
  - r==Nr: state ^= roundkey[Nr] only.
  - 1 ≤ r < Nr: InvShiftRows → InvSubBytes → AddRoundKey(r) → InvMixColumns.
  - r==0: InvShiftRows → InvSubBytes → AddRoundKey(0).
  - r decrements each cycle. After r==0, go to DONE.
- DONE:
  - out_data = state register; out_valid=1.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE; inputs are sampled only at the accept edge. Later changes to in_data/key do not affect the operation in flight.
- out_data and out_valid hold stable while out_valid && !out_ready.
- Simultaneous out_ready and in_valid in DONE: return to IDLE. The new block is accepted no earlier than the following cycle (no back-to-back accept).
- Reset low, at any time including mid-operation:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0.
  - Round and word counters cleared; key-cache valid bit cleared.
  - Partial results are discarded.
- Unsupported (N,Nr,Nk) triples are illegal; elaboration must fail.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=128'h0.
- Accept edge = rising clk with in_valid&&in_ready. in_ready drops in the next cycle.
- KEYEXP lasts 4*(Nr+1)-Nk cycles: 40 / 46 / 52 for 128 / 192 / 256.
- ROUND lasts Nr+1 cycles.
- out_valid rises L = 4*(Nr+1)-Nk+Nr+1 cycles after the accept edge: 51 / 59 / 67.
- DONE→IDLE takes 1 cycle after the out_ready edge. The minimum accept-to-accept interval is L+2 cycles.
- The critical path is one inverse round plus round-key read. The word store is read combinationally as 4 words at index 4r.

## Configuration
- KEY_CACHE_EN defined:
  - A valid bit and a copy of the last expanded key are kept.
  - If the accepted key equals the cached key and the valid bit is set, KEYEXP is skipped and the core goes directly to ROUND (r=Nr).
  - Latency L becomes Nr+1 (11/13/15).
  - The cache is invalidated by reset.
- KEY_CACHE_EN undefined: every accept performs full KEYEXP and L is always as above. No cache registers are present.

## Test plan
- AES-128: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff, out_valid exactly 51 cycles after accept.
- AES-192/256: key 000102…17 / 000102…1f, ciphertexts dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089 → plaintext 00112233445566778899aabbccddeeff at cycles 59 / 67.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and out_data stable, in_ready=0. Then pulse out_ready → in_ready=1 next cycle.
- Busy input: toggle in_valid, in_data and key during KEYEXP/ROUND → ignored, result unchanged.
- Reset mid-ROUND (reset low for 1 cycle at round 5) → out_valid=0, in_ready=1 immediately. A fresh AES-128 vector then decrypts correctly with full latency 51.
- KEY_CACHE_EN: two AES-128 blocks with the same key → second out_valid 11 cycles after accept. A different key → 51 cycles.
